// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm settings/timekeeping side and the alarm ringer.
// The master side supplies time, settings and buttons; the slave side
// (the ringer) returns the ringing/status outputs.
interface alarm_ringer_if #(
  parameter int MAX_MINUTES = 60,
  parameter int MAX_HOURS   = 24
);
  localparam int MW = $clog2(MAX_MINUTES);
  localparam int HW = $clog2(MAX_HOURS);

  logic          tick_sec;
  logic [MW-1:0] current_minutes;
  logic [HW-1:0] current_hours;
  logic          set_alarm;
  logic [MW-1:0] alarm_minutes;
  logic [HW-1:0] alarm_hours;
  logic          alarm_enable;
  logic          stop_btn;
  logic          snooze_btn;
  logic          buzzer;
  logic          ringing;
  logic          armed;
  logic          missed;
  logic [1:0]    snooze_count;

  modport master (
    output tick_sec, current_minutes, current_hours, set_alarm,
           alarm_minutes, alarm_hours, alarm_enable, stop_btn, snooze_btn,
    input  buzzer, ringing, armed, missed, snooze_count
  );

  modport slave (
    input  tick_sec, current_minutes, current_hours, set_alarm,
           alarm_minutes, alarm_hours, alarm_enable, stop_btn, snooze_btn,
    output buzzer, ringing, armed, missed, snooze_count
  );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm clock ringer: arms on a new alarm time, rings on a minute-change
// match, supports stop, limited snoozes and a ring timeout that flags a
// missed alarm. All outputs are registered.
module alarm_ringer #(
  parameter int MAX_MINUTES    = 60,
  parameter int MAX_HOURS      = 24,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input logic           clk,
  input logic           rst,
  alarm_ringer_if.slave bus
);
  localparam int MW = $clog2(MAX_MINUTES);
  localparam int HW = $clog2(MAX_HOURS);
  localparam int RW = $clog2(RING_SECONDS + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t        state;
  logic [MW-1:0] target_m;
  logic [HW-1:0] target_h;
  logic [MW-1:0] base_m;
  logic [HW-1:0] base_h;
  logic [RW-1:0] ring_cnt;
  logic          set_q;
  logic [MW-1:0] min_q;

  logic          set_edge;
  logic          min_chg;
  logic          match;
  logic [MW:0]   snz_m_raw;
  logic          m_carry;
  logic [MW-1:0] snz_m;
  logic [HW:0]   snz_h_raw;
  logic          h_carry;
  logic [HW-1:0] snz_h;
  logic [RW:0]   ring_next;
  logic          ring_done;
  logic          can_snooze;

  // Edge/minute-change detection and the snooze target with explicit modulo wrap.
  always_comb begin
    set_edge   = bus.set_alarm & ~set_q;
    min_chg    = bus.current_minutes != min_q;
    match      = min_chg && (bus.current_hours == target_h) &&
                 (bus.current_minutes == target_m);
    snz_m_raw  = {1'b0, bus.current_minutes} + (MW+1)'(SNOOZE_MINUTES);
    m_carry    = snz_m_raw >= (MW+1)'(MAX_MINUTES);
    snz_m      = m_carry ? MW'(snz_m_raw - (MW+1)'(MAX_MINUTES)) : MW'(snz_m_raw);
    snz_h_raw  = {1'b0, bus.current_hours} + (HW+1)'(m_carry);
    h_carry    = snz_h_raw >= (HW+1)'(MAX_HOURS);
    snz_h      = h_carry ? HW'(snz_h_raw - (HW+1)'(MAX_HOURS)) : HW'(snz_h_raw);
    ring_next  = {1'b0, ring_cnt} + (RW+1)'(1);
    ring_done  = ring_next >= (RW+1)'(RING_SECONDS);
    can_snooze = int'(bus.snooze_count) < MAX_SNOOZES;
  end

  // Ringer FSM with registered outputs; enable-off overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      target_m         <= '0;
      target_h         <= '0;
      base_m           <= '0;
      base_h           <= '0;
      ring_cnt         <= '0;
      set_q            <= 1'b0;
      min_q            <= '0;
      bus.buzzer       <= 1'b0;
      bus.ringing      <= 1'b0;
      bus.armed        <= 1'b0;
      bus.missed       <= 1'b0;
      bus.snooze_count <= '0;
    end else begin
      set_q <= bus.set_alarm;
      min_q <= bus.current_minutes;
      if (!bus.alarm_enable) begin
        state            <= IDLE;
        bus.buzzer       <= 1'b0;
        bus.ringing      <= 1'b0;
        bus.armed        <= 1'b0;
        bus.snooze_count <= '0;
      end else begin
        case (state)
          IDLE, ARMED, SNOOZE: begin
            if (set_edge) begin
              target_m         <= bus.alarm_minutes;
              target_h         <= bus.alarm_hours;
              base_m           <= bus.alarm_minutes;
              base_h           <= bus.alarm_hours;
              state            <= ARMED;
              bus.armed        <= 1'b1;
              bus.ringing      <= 1'b0;
              bus.buzzer       <= 1'b0;
              bus.snooze_count <= '0;
              bus.missed       <= 1'b0;
            end else if (state != IDLE && match) begin
              state       <= RINGING;
              ring_cnt    <= '0;
              bus.buzzer  <= 1'b1;
              bus.ringing <= 1'b1;
              bus.armed   <= 1'b0;
            end
          end
          RINGING: begin
            if (bus.stop_btn) begin
              state            <= ARMED;
              target_m         <= base_m;
              target_h         <= base_h;
              bus.snooze_count <= '0;
              bus.buzzer       <= 1'b0;
              bus.ringing      <= 1'b0;
              bus.armed        <= 1'b1;
            end else if (bus.snooze_btn && can_snooze) begin
              state            <= SNOOZE;
              target_m         <= snz_m;
              target_h         <= snz_h;
              bus.snooze_count <= bus.snooze_count + 2'd1;
              bus.buzzer       <= 1'b0;
              bus.ringing      <= 1'b0;
              bus.armed        <= 1'b1;
            end else if (bus.tick_sec) begin
              ring_cnt <= RW'(ring_next);
              if (ring_done) begin
                state            <= ARMED;
                target_m         <= base_m;
                target_h         <= base_h;
                bus.snooze_count <= '0;
                bus.missed       <= 1'b1;
                bus.buzzer       <= 1'b0;
                bus.ringing      <= 1'b0;
                bus.armed        <= 1'b1;
              end else begin
                bus.buzzer <= ~bus.buzzer;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: expected output vectors are queued as each
// step is driven and popped/compared after the clock edge that produces them.
module tb_alarm_ringer;
  logic clk;
  logic rst;

  alarm_ringer_if #(.MAX_MINUTES(60), .MAX_HOURS(24)) bus ();

  alarm_ringer #(
    .MAX_MINUTES(60), .MAX_HOURS(24), .RING_SECONDS(3),
    .SNOOZE_MINUTES(5), .MAX_SNOOZES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [5:0] obs;
  assign obs = {bus.buzzer, bus.ringing, bus.armed, bus.missed, bus.snooze_count};

  // {buzzer, ringing, armed, missed, snooze_count}
  function automatic logic [5:0] o(bit b, bit r, bit a, bit m, bit [1:0] sc);
    return {b, r, a, m, sc};
  endfunction

  task automatic push(string tag, logic [5:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_pop();
    exp_t x;
    x = sb.pop_front();
    n_assert++;
    assert (obs === x.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask

  task automatic step(string tag, bit tk, bit stp, bit snz, logic [5:0] e);
    bus.tick_sec   = tk;
    bus.stop_btn   = stp;
    bus.snooze_btn = snz;
    push(tag, e);
    @(posedge clk);
    #1;
    bus.tick_sec   = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    check_pop();
  endtask

  task automatic set_time(int h, int m);
    bus.current_hours   = 5'(h);
    bus.current_minutes = 6'(m);
  endtask

  initial begin
    rst               = 1'b0;
    bus.tick_sec      = 1'b0;
    bus.stop_btn      = 1'b0;
    bus.snooze_btn    = 1'b0;
    bus.set_alarm     = 1'b0;
    bus.alarm_enable  = 1'b1;
    bus.alarm_hours   = 5'd7;
    bus.alarm_minutes = 6'd30;
    set_time(7, 29);
    #5;
    push("reset_state", o(0, 0, 0, 0, 0));
    check_pop();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Arm and ring at 07:30, buzzer toggles per tick
    bus.set_alarm = 1'b1;
    step("arm", 0, 0, 0, o(0, 0, 1, 0, 0));
    step("armed_hold", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(7, 30);
    step("ring_start", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("buzz_tick1", 1, 0, 0, o(0, 1, 0, 0, 0));
    step("buzz_tick2", 1, 0, 0, o(1, 1, 0, 0, 0));
    step("stop", 0, 1, 0, o(0, 0, 1, 0, 0));

    // Stop beats snooze; snooze limit
    set_time(7, 29);
    step("rearm_wait", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(7, 30);
    step("ring2", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("stop_and_snooze", 0, 1, 1, o(0, 0, 1, 0, 0));
    set_time(7, 29);
    step("wait3", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(7, 30);
    step("ring3", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("snooze1", 0, 0, 1, o(0, 0, 1, 0, 1));
    set_time(7, 35);
    step("snooze1_ring", 0, 0, 0, o(1, 1, 0, 0, 1));
    step("snooze2", 0, 0, 1, o(0, 0, 1, 0, 2));
    set_time(7, 40);
    step("snooze2_ring", 0, 0, 0, o(1, 1, 0, 0, 2));
    step("snooze3", 0, 0, 1, o(0, 0, 1, 0, 3));
    set_time(7, 45);
    step("snooze3_ring", 0, 0, 0, o(1, 1, 0, 0, 3));
    step("snooze4_ignored", 0, 0, 1, o(1, 1, 0, 0, 3));
    step("stop_after_snoozes", 0, 1, 0, o(0, 0, 1, 0, 0));
    step("stop_outside_ring", 0, 1, 1, o(0, 0, 1, 0, 0));

    // Auto-stop after three ticks, rings again next day
    set_time(7, 29);
    step("wait4", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(7, 30);
    step("ring4", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("auto_tick1", 1, 0, 0, o(0, 1, 0, 0, 0));
    step("auto_tick2", 1, 0, 0, o(1, 1, 0, 0, 0));
    step("auto_stop", 1, 0, 0, o(0, 0, 1, 1, 0));
    set_time(7, 29);
    step("next_day_wait", 0, 0, 0, o(0, 0, 1, 1, 0));
    set_time(7, 30);
    step("next_day_ring", 0, 0, 0, o(1, 1, 0, 1, 0));
    step("next_day_stop", 0, 1, 0, o(0, 0, 1, 1, 0));

    // Snooze across midnight: 23:58 + 5 -> 00:03
    bus.set_alarm = 1'b0;
    step("set_low", 0, 0, 0, o(0, 0, 1, 1, 0));
    bus.alarm_hours   = 5'd23;
    bus.alarm_minutes = 6'd58;
    bus.set_alarm     = 1'b1;
    step("rearm_clears_missed", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(23, 57);
    step("wait_2357", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(23, 58);
    step("ring_2358", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("snooze_wrap", 0, 0, 1, o(0, 0, 1, 0, 1));
    set_time(0, 0);
    step("no_ring_0000", 0, 0, 0, o(0, 0, 1, 0, 1));
    set_time(0, 3);
    step("ring_0003", 0, 0, 0, o(1, 1, 0, 0, 1));

    // Enable off mid-ring, no re-arm without a fresh edge
    bus.alarm_enable = 1'b0;
    step("disable_idle", 0, 0, 0, o(0, 0, 0, 0, 0));
    bus.alarm_enable = 1'b1;
    step("enable_stays_idle", 0, 0, 0, o(0, 0, 0, 0, 0));
    set_time(0, 2);
    step("idle_wait", 0, 0, 0, o(0, 0, 0, 0, 0));
    set_time(0, 3);
    step("idle_no_ring", 0, 0, 0, o(0, 0, 0, 0, 0));

    // Async reset mid-ring
    bus.set_alarm = 1'b0;
    step("set_low2", 0, 0, 0, o(0, 0, 0, 0, 0));
    bus.set_alarm = 1'b1;
    step("arm_2358", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(23, 57);
    step("wait_b", 0, 0, 0, o(0, 0, 1, 0, 0));
    set_time(23, 58);
    step("ring_b", 0, 0, 0, o(1, 1, 0, 0, 0));
    step("ring_b_tick1", 1, 0, 0, o(0, 1, 0, 0, 0));
    step("ring_b_tick2", 1, 0, 0, o(1, 1, 0, 0, 0));
    step("ring_b_auto", 1, 0, 0, o(0, 0, 1, 1, 0));
    set_time(23, 57);
    step("wait_c", 0, 0, 0, o(0, 0, 1, 1, 0));
    set_time(23, 58);
    step("ring_c", 0, 0, 0, o(1, 1, 0, 1, 0));
    step("snooze_c", 0, 0, 1, o(0, 0, 1, 1, 1));
    set_time(0, 3);
    step("ring_c_0003", 0, 0, 0, o(1, 1, 0, 1, 1));
    #5;
    bus.set_alarm = 1'b0;
    rst = 1'b0;
    #1;
    push("async_reset", o(0, 0, 0, 0, 0));
    check_pop();
    #3 rst = 1'b1;
    set_time(0, 2);
    step("post_reset_wait", 0, 0, 0, o(0, 0, 0, 0, 0));
    set_time(0, 3);
    step("post_reset_no_ring", 0, 0, 0, o(0, 0, 0, 0, 0));
    set_time(23, 58);
    step("post_reset_no_ring2", 0, 0, 0, o(0, 0, 0, 0, 0));
    bus.set_alarm = 1'b1;
    step("post_reset_arm", 0, 0, 0, o(0, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 SHALL have parameter MAX_MINUTES, 60, minutes per hour; minute fields are $clog2(MAX_MINUTES) bits wide (6 bits at default).
REQ-002 SHALL have parameter MAX_HOURS, 24, hours per day; hour fields are $clog2(MAX_HOURS) bits wide (5 bits at default).
REQ-003 SHALL have parameter RING_SECONDS, 60, tick_sec pulses before ringing auto-stops.
REQ-004 SHALL have parameter SNOOZE_MINUTES, 5, snooze offset in minutes, range 1..MAX_MINUTES-1.
REQ-005 SHALL have parameter MAX_SNOOZES, 3, snoozes allowed per alarm event.
REQ-006 SHALL have ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-low.
- tick_sec  in  1  one-cycle pulse, once per second.
- current_minutes  in  MW  live time, minutes.
- current_hours  in  HW  live time, hours.
- set_alarm  in  1  level from settings block; a rising edge means a new alarm time is valid.
- alarm_minutes  in  MW  programmed alarm minutes.
- alarm_hours  in  HW  programmed alarm hours.
- alarm_enable  in  1  master enable switch; 1 = enabled.
- stop_btn  in  1  one-cycle pulse; stops ringing.
- snooze_btn  in  1  one-cycle pulse; requests snooze.
- buzzer  out  1  drive for the audible output.
- ringing  out  1  high while in RINGING.
- armed  out  1  high in ARMED or SNOOZE.
- missed  out  1  sticky; set on auto-stop.
- snooze_count  out  2  snoozes used in the current event.

Function
REQ-007 SHALL implement FSM states IDLE, ARMED, RINGING, SNOOZE, and SHALL register all outputs.
REQ-008 SHALL detect a set_alarm rising edge with a registered copy of set_alarm; the edge is the cycle where set_alarm=1 and the registered copy=0.
REQ-009 SHALL latch target = {alarm_hours, alarm_minutes} and base = the same value on that edge when in IDLE, ARMED or SNOOZE with alarm_enable=1, then go to ARMED with snooze_count=0.
REQ-010 SHALL ignore a set_alarm edge while in RINGING.
REQ-011 SHALL evaluate a match only on a minute-change cycle: current_minutes differs from its registered copy of the previous cycle.
REQ-012 SHALL, on a match in ARMED or SNOOZE (target equals current time), enter RINGING on the next cycle with ring_cnt=0 and buzzer=1.
REQ-013 SHALL toggle buzzer on each tick_sec while in RINGING, and SHALL hold buzzer=0 in every other state.
REQ-014 SHALL increment ring_cnt on each tick_sec in RINGING.
REQ-015 SHALL auto-stop when ring_cnt reaches RING_SECONDS: go to ARMED, target=base, snooze_count=0, missed=1.
REQ-016 SHALL, on stop_btn in RINGING, go to ARMED with target=base and snooze_count=0; missed unchanged.
REQ-017 SHALL, on snooze_btn in RINGING with snooze_count<MAX_SNOOZES:
- go to SNOOZE;
- snooze_count += 1;
- target = current time + SNOOZE_MINUTES, minutes modulo MAX_MINUTES, carry into hours modulo MAX_HOURS (23:58 + 5 -> 00:03).
REQ-018 SHALL ignore snooze_btn when snooze_count=MAX_SNOOZES; ringing continues.
REQ-019 SHALL apply same-cycle priority: alarm_enable=0 > stop_btn > snooze_btn > auto-stop > match.
REQ-020 SHALL, whenever alarm_enable=0, go to IDLE on the next cycle with buzzer=0, ringing=0 and snooze_count=0; target is retained but not compared.
REQ-021 SHALL stay in IDLE when alarm_enable returns to 1 until the next set_alarm rising edge.
REQ-022 SHALL clear missed only on a set_alarm rising edge accepted per REQ-009.
REQ-023 SHALL ignore stop_btn and snooze_btn outside RINGING.
REQ-024 SHALL perform all time arithmetic in widths 1 bit wider than the operand, then reduce modulo; no wrap by overflow.

Reset
REQ-025 SHALL, on rst low, asynchronously set: state=IDLE; buzzer=0, ringing=0, armed=0, missed=0, snooze_count=0; target=base=0; ring_cnt=0; both edge and minute registered copies=0.
REQ-026 SHALL treat reset during RINGING as silencing immediately (buzzer=0) without waiting for a clock edge.
REQ-027 SHALL require a fresh set_alarm rising edge after reset before arming.

Verification
REQ-028 Arm/ring: enable=1, alarm 07:30 set, time steps 07:29 -> 07:30 -> armed=1 then ringing=1 and buzzer=1 one cycle after the minute change; buzzer toggles on each tick_sec.
REQ-029 Snooze wrap: alarm 23:58 ringing, snooze_btn -> state SNOOZE, snooze_count=1; time reaches 00:03 -> ringing again.
REQ-030 Auto-stop (RING_SECONDS=3): 3 tick_sec with no button -> ringing=0, armed=1, missed=1; time at 07:30 on the next day rings again.
REQ-031 Priority: stop_btn and snooze_btn in the same cycle -> ARMED, snooze_count=0; 4th snooze with MAX_SNOOZES=3 ignored, ringing stays 1.
REQ-032 Enable off mid-ring: alarm_enable=0 -> buzzer=0 next cycle, state IDLE; enable=1 again with no set_alarm edge and time at target -> no ring.
REQ-033 Async reset mid-ring: rst low between clock edges -> buzzer=0 immediately; all outputs 0; time at target afterwards -> no ring until set_alarm re-edges.
